// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle of the RV32M multiply/divide unit.
// master drives start/funct3/op_a/op_b/rd_in; slave returns busy/done/result/rd_out/wb_enable.
interface muldiv_unit_if;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [4:0]  rd_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        wb_enable;

  modport master (
    output start, funct3, op_a, op_b, rd_in,
    input  busy, done, result, rd_out, wb_enable
  );

  modport slave (
    input  start, funct3, op_a, op_b, rd_in,
    output busy, done, result, rd_out, wb_enable
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M mul/div (32 iterations, then sign fix), rst async active-low.
// Ports: clk, rst, m (muldiv_unit_if.slave). Option macro MULDIV_EARLY_OUT_EN: trivial ops skip to DONE.
module muldiv_unit #(
  parameter int XLEN       = 32,
  parameter int ITER_CNT_W = 6
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave m
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

  localparam logic [ITER_CNT_W-1:0] LAST = ITER_CNT_W'(XLEN - 1);

  state_t state_q, state_d;

  logic [ITER_CNT_W-1:0] cnt;
  logic [2:0]            f3_q;
  logic [XLEN-1:0]       a_q, b_q, mb;
  logic [4:0]            rd_c, rd_q;
  logic                  neg_q, neg_r;
  logic [2*XLEN-1:0]     prod;
  logic [XLEN-1:0]       rem, quo, res_q;

  logic            accept, early;
  logic [XLEN-1:0] early_val;

  // Divide-by-zero, signed overflow and zero multiplicand all have fixed answers.
  function automatic logic [32:0] trivial(
    input logic [2:0]  f,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [32:0] r;
    r = '0;
    if (f[2]) begin
      if (b == '0)
        r = {1'b1, f[1] ? a : 32'hFFFF_FFFF};
      else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
        r = {1'b1, f[1] ? 32'h0 : 32'h8000_0000};
    end else if (a == '0 || b == '0) begin
      r = {1'b1, 32'h0};
    end
    return r;
  endfunction

  assign accept = m.start && (state_q == IDLE || state_q == DONE);

`ifdef MULDIV_EARLY_OUT_EN
  logic [32:0] trv_in;
  assign trv_in    = trivial(m.funct3, m.op_a, m.op_b);
  assign early     = accept && trv_in[32];
  assign early_val = trv_in[31:0];
`else
  assign early     = 1'b0;
  assign early_val = '0;
`endif

  // Operand signedness: MULH/MULHSU/DIV/REM treat a as signed; MUL/MULH/DIV/REM treat b as signed.
  logic            sa, sb, na, nb;
  logic [XLEN-1:0] abs_a, abs_b;

  always_comb begin
    sa = 1'b0;
    sb = 1'b0;
    unique case (m.funct3)
      3'd0:          sb = 1'b1;
      3'd1, 3'd4, 3'd6: begin
        sa = 1'b1;
        sb = 1'b1;
      end
      3'd2:          sa = 1'b1;
      default: ;
    endcase
  end

  assign na    = sa & m.op_a[XLEN-1];
  assign nb    = sb & m.op_b[XLEN-1];
  assign abs_a = na ? (~m.op_a + 1'b1) : m.op_a;
  assign abs_b = nb ? (~m.op_b + 1'b1) : m.op_b;

  // Shift-add step: add multiplicand into the high half, then shift right with carry.
  logic [XLEN:0]     sum;
  logic [2*XLEN-1:0] prod_nx;
  assign sum     = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, mb} : '0);
  assign prod_nx = {sum, prod[XLEN-1:1]};

  // Restoring divide step on a 33-bit trial remainder.
  logic [XLEN:0] shl, trial;
  assign shl   = {rem, quo[XLEN-1]};
  assign trial = shl - {1'b0, mb};

  logic [2*XLEN-1:0] pfix;
  logic [XLEN-1:0]   qfix, rfix, fix_val;
  logic [32:0]       trv_fix;

  assign pfix    = neg_q ? (~prod + 1'b1) : prod;
  assign qfix    = neg_q ? (~quo + 1'b1) : quo;
  assign rfix    = neg_r ? (~rem + 1'b1) : rem;
  assign trv_fix = trivial(f3_q, a_q, b_q);

  always_comb begin
    fix_val = '0;
    if (trv_fix[32]) begin
      fix_val = trv_fix[31:0];
    end else begin
      unique case (f3_q)
        3'd0:             fix_val = pfix[XLEN-1:0];
        3'd1, 3'd2, 3'd3: fix_val = pfix[2*XLEN-1:XLEN];
        3'd4, 3'd5:       fix_val = qfix;
        default:          fix_val = rfix;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = early ? DONE : CALC;
      CALC: if (cnt == LAST) state_d = FIX;
      FIX:  state_d = DONE;
      DONE: state_d = accept ? (early ? DONE : CALC) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt     <= '0;
      f3_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      mb      <= '0;
      rd_c    <= '0;
      rd_q    <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      prod    <= '0;
      rem     <= '0;
      quo     <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        f3_q  <= m.funct3;
        a_q   <= m.op_a;
        b_q   <= m.op_b;
        rd_c  <= m.rd_in;
        mb    <= abs_b;
        prod  <= {{XLEN{1'b0}}, abs_a};
        quo   <= abs_a;
        rem   <= '0;
        cnt   <= '0;
        neg_q <= na ^ nb;
        neg_r <= na;
        if (early) begin
          res_q <= early_val;
          rd_q  <= m.rd_in;
        end
      end else if (state_q == CALC) begin
        cnt <= cnt + 1'b1;
        if (f3_q[2]) begin
          rem <= trial[XLEN] ? shl[XLEN-1:0] : trial[XLEN-1:0];
          quo <= {quo[XLEN-2:0], ~trial[XLEN]};
        end else begin
          prod <= prod_nx;
        end
      end else if (state_q == FIX) begin
        res_q <= fix_val;
        rd_q  <= rd_c;
      end
    end
  end

  assign m.busy      = (state_q == CALC) || (state_q == FIX);
  assign m.done      = (state_q == DONE);
  assign m.result    = res_q;
  assign m.rd_out    = rd_q;
  assign m.wb_enable = m.done && (rd_q != '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit with hand-computed results.
// Covers reset, all funct3 ops, special cases, ignored start, back-to-back, async reset.
module tb_muldiv_unit;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int TRIV_LAT = 1;
`else
  localparam int TRIV_LAT = 34;
`endif

  logic clk;
  logic rst;
  muldiv_unit_if bus ();

  muldiv_unit dut (
    .clk (clk),
    .rst (rst),
    .m   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
    bus.start  = 1'b1;
    bus.funct3 = f;
    bus.op_a   = a;
    bus.op_b   = b;
    bus.rd_in  = rd;
  endtask

  // Counts edges from the start edge (edge 1) until done is seen; 999 on timeout.
  task automatic wait_done(input int init, output int lat);
    lat = init;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) bus.start = 1'b0;
      if (bus.done) return;
    end
    lat = 999;
  endtask

  typedef struct {
    logic [2:0]  f;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    bit          triv;
  } vec_t;

  vec_t vt[14];

  initial begin
    int lat;
    int seen;
    vt[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0};
    vt[1]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
    vt[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0};
    vt[3]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0};
    vt[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0};
    vt[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0};
    vt[6]  = '{3'd5, 32'h8000_0000,  32'd3,         32'h2AAA_AAAA, 1'b0};
    vt[7]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1};
    vt[8]  = '{3'd7, 32'd5,          32'd0,         32'd5,         1'b1};
    vt[9]  = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1};
    vt[10] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vt[11] = '{3'd0, 32'd0,          32'h1234_5678, 32'h0000_0000, 1'b1};
    vt[12] = '{3'd7, 32'd100,        32'd7,         32'd2,         1'b0};
    vt[13] = '{3'd4, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0};

    n_vec      = 0;
    n_err      = 0;
    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.funct3 = '0;
    bus.op_a   = '0;
    bus.op_b   = '0;
    bus.rd_in  = '0;

    #3;
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_wb", {31'b0, bus.wb_enable}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_rd", {27'b0, bus.rd_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    foreach (vt[i]) begin
      start_op(vt[i].f, vt[i].a, vt[i].b, 5'(i + 1));
      wait_done(0, lat);
      chk($sformatf("v%0d_result", i), bus.result, vt[i].exp);
      chk($sformatf("v%0d_lat", i), lat, vt[i].triv ? TRIV_LAT : 34);
      chk($sformatf("v%0d_rd", i), {27'b0, bus.rd_out}, i + 1);
      chk($sformatf("v%0d_wb", i), {31'b0, bus.wb_enable}, 32'd1);
      @(negedge clk);
    end

    // Start pulsed mid-CALC must not disturb the running MULHU.
    start_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start_op(3'd5, 32'd100, 32'd3, 5'd4);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("ign_busy", {31'b0, bus.busy}, 32'd1);
    wait_done(6, lat);
    chk("ign_result", bus.result, 32'hFFFF_FFFE);
    chk("ign_lat", lat, 34);
    chk("ign_rd", {27'b0, bus.rd_out}, 32'd9);

    // Back-to-back: start during the DONE cycle.
    start_op(3'd5, 32'd100, 32'd7, 5'd3);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk("b2b_busy", {31'b0, bus.busy}, 32'd1);
    chk("b2b_done", {31'b0, bus.done}, 32'd0);
    chk("b2b_hold", bus.result, 32'hFFFF_FFFE);
    wait_done(1, lat);
    chk("b2b_result", bus.result, 32'd14);
    chk("b2b_lat", lat, 34);
    chk("b2b_rd", {27'b0, bus.rd_out}, 32'd3);
    @(negedge clk);

    // Asynchronous reset at iteration 10.
    start_op(3'd0, 32'd3, 32'd5, 5'd7);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", {31'b0, bus.busy}, 32'd0);
    chk("arst_done", {31'b0, bus.done}, 32'd0);
    chk("arst_result", bus.result, 32'd0);
    chk("arst_rd", {27'b0, bus.rd_out}, 32'd0);
    repeat (2) @(negedge clk);
    rst  = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done || bus.busy) seen++;
    end
    chk("arst_quiet", seen, 32'd0);

    // Normal op after reset, rd=0 suppresses write-back.
    @(negedge clk);
    start_op(3'd0, 32'd3, 32'd5, 5'd0);
    wait_done(0, lat);
    chk("rd0_result", bus.result, 32'd15);
    chk("rd0_lat", lat, 34);
    chk("rd0_done", {31'b0, bus.done}, 32'd1);
    chk("rd0_wb", {31'b0, bus.wb_enable}, 32'd0);
    @(posedge clk);
    #1;
    chk("done_pulse", {31'b0, bus.done}, 32'd0);
    chk("hold_result", bus.result, 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
